filter_tap_line: RTL and testbench
==================================

# filter_tap_line

Parametrised sample-history delay line for the fixed-point filter datapath. It holds the newest `DEPTH` samples (`fk`, `fk_1`, …, `fk_DEPTH-1`), advances on a sample strobe in the system clock domain, and tracks how many taps hold valid data. It also provides a synchronous flush and a registered indexed read port for sequential MAC engines. It sits between the ADC/sample-formatting stage and the filter arithmetic.

## Interface
- `W`, 50: sample width in bits (2×N of the Q-format, N=25).
- `DEPTH`, 3: number of taps; legal range 2..32.
- `IW`, $clog2(DEPTH): width of `rd_idx` (derived; not overridden).
- `CW`, $clog2(DEPTH+1): width of `fill_count` (derived; not overridden).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `clear`  in  1  synchronous flush of the history; no effect on parameters.
- `shift_en`  in  1  sample strobe; one-cycle pulse accepts `din`.
- `din`  in  W  new sample, two's complement.
- `rd_idx`  in  IW  tap index for the read port (0 = newest).
- `taps`  out  DEPTH*W  packed taps; bits [W-1:0] = tap0 (`fk`), bits [2W-1:W] = tap1 (`fk_1`), and so on.
- `rd_data`  out  W  registered copy of tap[`rd_idx`].
- `fill_count`  out  CW  number of valid taps, 0..DEPTH.
- `primed`  out  1  high when `fill_count == DEPTH`.
- `shift_done`  out  1  one-cycle pulse after each accepted shift.

## Operation
- **Accepted shift:** `shift_en=1`, `clear=0`, `reset=0` at a rising edge.
  - tap0 ← `din`.
  - tap k ← tap k-1 for k = 1..DEPTH-1.
  - tap DEPTH-1's old value is discarded.
- **Hold:** with `shift_en=0`, all taps hold their values.
  - `shift_en` is level-sampled. If it stays high for M cycles, M shifts occur.
- **fill_count:**
  - Increments by 1 on each accepted shift.
  - Saturates at DEPTH; never wraps.
- **primed:** combinational compare of `fill_count` with DEPTH.
- **clear:**
  - All taps ← 0, `fill_count` ← 0, `shift_done` ← 0.
  - `clear` has priority over `shift_en`. A simultaneous shift is dropped and `din` is lost.
- **reset:**
  - Same effect as `clear`, and also `rd_data` ← 0.
  - `reset` has priority over everything, including in the middle of a shift burst.
- **Read port:**
  - `rd_data` ← tap[`rd_idx`] on every edge, sampling the taps before that edge's update.
  - If `rd_idx` ≥ DEPTH (possible when DEPTH is not a power of 2), `rd_data` ← 0.
- **Data path:** pure storage. No sign extension, truncation or arithmetic; values pass through bit-exact.

## Timing
- **Reset values:** `taps`=0, `rd_data`=0, `fill_count`=0, `primed`=0, `shift_done`=0.
- **Shift latency:** `din` appears on tap0 (`taps[W-1:0]`) 1 cycle after the accepted edge, and on tap k after k+1 accepted shifts.
- **shift_done:** high for exactly the cycle following each accepted shift.
  - During back-to-back shifts it stays high continuously.
  - It is low in the cycle after a shift that was dropped by `clear`.
- **Read latency:** 1 cycle from `rd_idx`. If a shift and a read happen on the same edge, `rd_data` shows the pre-shift tap.
- **primed:** rises in the same cycle `fill_count` reaches DEPTH, i.e. after the DEPTH-th accepted shift following reset or clear.
- **No handshake back-pressure:** the block is always ready and accepts one sample per cycle indefinitely.

## Test plan
1. **Reset:** assert `reset` with `shift_en=1`, `din`=0x3_FFFF_FFFF_FFFF → after release, all outputs are 0 and `fill_count`=0.
2. **Fill and prime (DEPTH=3):** strobe `din`=1, 2, 3 on non-consecutive cycles → `taps` = {1,2,3} (tap2..tap0); `fill_count` goes 1, 2, 3; `primed` rises after the third shift; `shift_done` gives three isolated pulses.
3. **Burst overflow:** hold `shift_en` for 5 cycles with `din`=10..14 → `taps` = {12,13,14}; `fill_count` stays at 3 (saturated); `shift_done` is high for 5 consecutive cycles.
4. **Clear beats shift:** with the block primed, assert `clear` and `shift_en` together with `din`=0x55 → all taps 0, `fill_count`=0, `primed`=0, no `shift_done` pulse; the next shift gives tap0=next `din`, `fill_count`=1.
5. **Read port:** with taps {7,8,9}, sweep `rd_idx`=0, 1, 2, 3 → `rd_data` = 9, 8, 7, 0, each one cycle later. Then shift `din`=5 on the same edge as `rd_idx`=0 → `rd_data`=9, followed by 5.
6. **Sign and width:** with W=50, shift in 0x2_0000_0000_0000 (negative) → the value is bit-exact on tap0 and on `rd_data`, then on tap DEPTH-1 after DEPTH shifts.

Source files
------------

// File: rtl/filter_tap_line.sv
// filter_tap_line: sample-history delay line with fill tracking, flush and registered indexed read.
module filter_tap_line #(
    parameter int W     = 50,
    parameter int DEPTH = 3,
    parameter int IW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [W-1:0]         din,
    input  logic [IW-1:0]        rd_idx,
    output logic [DEPTH*W-1:0]   taps,
    output logic [W-1:0]         rd_data,
    output logic [CW-1:0]        fill_count,
    output logic                 primed,
    output logic                 shift_done
);
    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

    logic [DEPTH*W-1:0] r_taps;
    logic [W-1:0]       r_rd_data;
    logic [CW-1:0]      r_fill;
    logic               r_done;
    logic [W-1:0]       w_rd_sel;

    // indices at or beyond DEPTH match no tap and read as zero
    always_comb begin
        w_rd_sel = '0;
        for (int k = 0; k < DEPTH; k++)
            if (rd_idx == IW'(k)) w_rd_sel = r_taps[k*W +: W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taps    <= '0;
            r_rd_data <= '0;
            r_fill    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_rd_data <= w_rd_sel;
            if (clear) begin
                r_taps <= '0;
                r_fill <= '0;
                r_done <= 1'b0;
            end else begin
                r_done <= shift_en;
                if (shift_en) begin
                    r_taps <= {r_taps[(DEPTH-1)*W-1:0], din};
                    r_fill <= (r_fill == LP_FULL) ? r_fill : r_fill + 1'b1;
                end
            end
        end
    end

    assign taps       = r_taps;
    assign rd_data    = r_rd_data;
    assign fill_count = r_fill;
    assign primed     = (r_fill == LP_FULL);
    assign shift_done = r_done;
endmodule

// File: tb/tb_filter_tap_line.sv
// tb_filter_tap_line: queue-based history model checked every cycle, plus literal spot checks.
module tb_filter_tap_line;
    localparam int W = 50;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           clear = 1'b0;
    logic           shift_en = 1'b0;
    logic [W-1:0]   din = '0;
    logic [1:0]     rd_idx = '0;
    logic [D*W-1:0] taps;
    logic [W-1:0]   rd_data;
    logic [1:0]     fill_count;
    logic           primed;
    logic           shift_done;

    int n_checks = 0;
    int n_fail = 0;

    filter_tap_line #(.W(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en),
        .din(din), .rd_idx(rd_idx), .taps(taps), .rd_data(rd_data),
        .fill_count(fill_count), .primed(primed), .shift_done(shift_done)
    );

    always #5 clk = ~clk;

    // model: newest sample at the front of the queue, oldest at the back
    logic [W-1:0] mq[$];
    int           m_cnt;
    bit           m_done;
    logic [W-1:0] m_rd;
    bit           m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq = {};
            for (int i = 0; i < D; i++) mq.push_back('0);
            m_cnt = 0; m_done = 0; m_rd = '0; m_valid = 1;
        end else if (m_valid) begin
            m_rd = (int'(rd_idx) < D) ? mq[rd_idx] : '0;
            if (clear) begin
                for (int i = 0; i < D; i++) mq[i] = '0;
                m_cnt = 0; m_done = 0;
            end else if (shift_en) begin
                mq.push_front(din);
                void'(mq.pop_back());
                m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
                m_done = 1;
            end else m_done = 0;
        end
    end

    task automatic chk(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_taps", taps, {mq[2], mq[1], mq[0]});
            chk("model_rd_data", {100'd0, rd_data}, {100'd0, m_rd});
            chk("model_fill", {148'd0, fill_count}, (D*W)'(m_cnt));
            chk("model_primed", {149'd0, primed}, (D*W)'(m_cnt == D));
            chk("model_done", {149'd0, shift_done}, (D*W)'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_one(input logic [W-1:0] v);
        shift_en = 1'b1; din = v;
        step();
        chk("pulse_hi", {149'd0, shift_done}, 1);
        shift_en = 1'b0;
        step();
        chk("pulse_lo", {149'd0, shift_done}, 0);
    endtask

    initial begin
        shift_en = 1'b1;
        din = 50'h3_FFFF_FFFF_FFFF;
        repeat (3) step();
        reset = 1'b0; shift_en = 1'b0;
        step();
        chk("rst_taps", taps, 0);
        chk("rst_rd", {100'd0, rd_data}, 0);
        chk("rst_fill", {148'd0, fill_count}, 0);
        chk("rst_primed", {149'd0, primed}, 0);

        shift_one(1);
        chk("fill1", {148'd0, fill_count}, 1);
        shift_one(2);
        chk("fill2", {148'd0, fill_count}, 2);
        chk("primed_early", {149'd0, primed}, 0);
        shift_one(3);
        chk("fill3", {148'd0, fill_count}, 3);
        chk("primed", {149'd0, primed}, 1);
        chk("taps123", taps, {50'd1, 50'd2, 50'd3});

        for (int i = 0; i < 5; i++) begin
            shift_en = 1'b1; din = W'(10 + i);
            step();
            chk("burst_done", {149'd0, shift_done}, 1);
            chk("burst_fill", {148'd0, fill_count}, 3);
        end
        shift_en = 1'b0;
        step();
        chk("burst_taps", taps, {50'd12, 50'd13, 50'd14});

        clear = 1'b1; shift_en = 1'b1; din = 50'h55;
        step();
        chk("clr_taps", taps, 0);
        chk("clr_fill", {148'd0, fill_count}, 0);
        chk("clr_primed", {149'd0, primed}, 0);
        chk("clr_done", {149'd0, shift_done}, 0);
        clear = 1'b0; din = 50'h66;
        step();
        chk("post_clr_tap0", {100'd0, taps[W-1:0]}, 150'h66);
        chk("post_clr_fill", {148'd0, fill_count}, 1);
        shift_en = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;

        shift_one(7); shift_one(8); shift_one(9);
        chk("taps789", taps, {50'd7, 50'd8, 50'd9});
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            step();
            chk("rd_sweep", {100'd0, rd_data}, (i == 3) ? 150'd0 : 150'(9 - i));
        end
        rd_idx = 2'd0; shift_en = 1'b1; din = 50'd5;
        step();
        chk("rd_preshift", {100'd0, rd_data}, 150'd9);
        shift_en = 1'b0;
        step();
        chk("rd_postshift", {100'd0, rd_data}, 150'd5);

        shift_one(50'h2_0000_0000_0000);
        chk("neg_tap0", {100'd0, taps[W-1:0]}, {100'd0, 50'h2_0000_0000_0000});
        chk("neg_rd", {100'd0, rd_data}, {100'd0, 50'h2_0000_0000_0000});
        shift_one(50'd1);
        shift_one(50'd2);
        chk("neg_tap2", {100'd0, taps[3*W-1:2*W]}, {100'd0, 50'h2_0000_0000_0000});

        shift_en = 1'b1; din = 50'd77;
        step();
        reset = 1'b1;
        step();
        chk("midburst_rst_taps", taps, 0);
        chk("midburst_rst_done", {149'd0, shift_done}, 0);
        reset = 1'b0; shift_en = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
